// File: rtl/div_8b_seq_if.sv
// Start/done handshake and operand/result bus of the sequential 8-bit divider.
// The master is the ALU controller and the slave is the divider.
interface div_8b_seq_if;
  logic        inicio;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [7:0]  quociente;
  logic        fim;
  logic [15:0] resto_out;

  modport master (
    output inicio, A, B,
    input  quociente, fim, resto_out
  );

  modport slave (
    input  inicio, A, B,
    output quociente, fim, resto_out
  );
endinterface

// File: rtl/div_8b_seq.sv
// Unsigned 8-bit restoring divider, one quotient bit per clock.
// Uses a start/done handshake; the result is held until the next start.
module div_8b_seq (
  input logic         clk,
  input logic         rst,
  div_8b_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_dvd;
  logic [7:0] r_dvs;
  logic [7:0] r_rem;
  logic [7:0] r_quo;
  logic [3:0] r_cnt;
  logic [7:0] r_quociente;
  logic [7:0] r_resto;
  logic       r_fim;

  logic [8:0] w_shift;
  logic       w_ge;
  logic [7:0] w_sub;
  logic       w_start;

  // The partial remainder is always below the divisor, so the difference fits in 8 bits.
  assign w_shift = {r_rem, r_dvd[7]};
  assign w_ge    = w_shift >= {1'b0, r_dvs};
  assign w_sub   = w_shift[7:0] - r_dvs;
  assign w_start = bus.inicio &&
                   (r_state == S_IDLE || r_state == S_DONE);

  assign bus.quociente = r_quociente;
  assign bus.resto_out = {8'h00, r_resto};
  assign bus.fim       = r_fim;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_quociente <= '0;
      r_resto     <= '0;
      r_fim       <= 1'b0;
    end else if (w_start) begin
      r_dvd <= bus.A;
      r_dvs <= bus.B;
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      if (bus.B == 8'd0) begin
        r_quociente <= 8'hFF;
        r_resto     <= bus.A;
        r_fim       <= 1'b1;
        r_state     <= S_DONE;
      end else begin
        r_fim   <= 1'b0;
        r_state <= S_CALC;
      end
    end else if (r_state == S_CALC) begin
      if (r_cnt == 4'd8) begin
        r_quociente <= r_quo;
        r_resto     <= r_rem;
        r_fim       <= 1'b1;
        r_state     <= S_DONE;
      end else begin
        r_dvd <= {r_dvd[6:0], 1'b0};
        r_rem <= w_ge ? w_sub : w_shift[7:0];
        r_quo <= {r_quo[6:0], w_ge};
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_div_8b_seq.sv
// Directed self-checking bench for the sequential 8-bit divider.
// Expected quotients, remainders and latencies are hand-computed constants.
module tb_div_8b_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   lat;

  div_8b_seq_if bus ();

  div_8b_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.A      = a;
    bus.B      = b;
    bus.inicio = 1'b1;
    @(negedge clk);
    bus.inicio = 1'b0;
  endtask

  // Counts rising edges after the accepting edge until fim is seen.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.fim !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input int q, input int r, input int l);
    start_op(a, b);
    wait_done(lat);
    check({tag, "_lat"}, lat, l);
    check({tag, "_q"}, int'(bus.quociente), q);
    check({tag, "_r"}, int'(bus.resto_out), r);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bus.inicio = 1'b0;
    bus.A      = '0;
    bus.B      = '0;

    // 1) reset state, then 7/2
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", int'(bus.quociente), 0);
    check("rst_r", int'(bus.resto_out), 0);
    check("rst_fim", int'(bus.fim), 0);
    rst = 1'b1;
    run("t7_2", 8'd7, 8'd2, 3, 1, 9);

    // 2) 200/10, fim held
    do_reset();
    run("t200_10", 8'd200, 8'd10, 20, 0, 9);
    repeat (5) @(negedge clk);
    check("hold_fim", int'(bus.fim), 1);
    check("hold_q", int'(bus.quociente), 20);

    // 3) 32/7 then back-to-back 255/1
    do_reset();
    run("t32_7", 8'd32, 8'd7, 4, 4, 9);
    start_op(8'd255, 8'd1);
    check("b2b_fimclr", int'(bus.fim), 0);
    check("b2b_qhold", int'(bus.quociente), 4);
    wait_done(lat);
    check("t255_1_lat", lat, 9);
    check("t255_1_q", int'(bus.quociente), 255);
    check("t255_1_r", int'(bus.resto_out), 0);

    // 4) boundaries
    run("t5_9", 8'd5, 8'd9, 0, 5, 9);
    run("t9_9", 8'd9, 8'd9, 1, 0, 9);
    run("t0_3", 8'd0, 8'd3, 0, 0, 9);
    run("t255_255", 8'd255, 8'd255, 1, 0, 9);
    run("t250_16", 8'd250, 8'd16, 15, 10, 9);

    // 5) divide by zero
    run("t77_0", 8'd77, 8'd0, 255, 77, 0);

    // 6) reset mid-calculation
    run("t100_7", 8'd100, 8'd7, 14, 2, 9);
    start_op(8'd100, 8'd3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_q", int'(bus.quociente), 0);
    check("abort_r", int'(bus.resto_out), 0);
    check("abort_fim", int'(bus.fim), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_done(lat);
    check("abort_nofim", lat, 20);
    run("t100_3", 8'd100, 8'd3, 33, 1, 9);

    // inputs disturbed mid-calculation
    start_op(8'd100, 8'd3);
    repeat (2) @(negedge clk);
    bus.inicio = 1'b1;
    bus.A      = 8'd5;
    bus.B      = 8'd7;
    @(negedge clk);
    bus.inicio = 1'b0;
    lat = 3;
    while (bus.fim !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("dist_lat", lat, 9);
    check("dist_q", int'(bus.quociente), 33);
    check("dist_r", int'(bus.resto_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
